// File: rtl/wfetch_pkg.sv
// Shared types and default dimensions for the weight fetch sequencer and the weight buffer.
package wfetch_pkg;

    localparam int DEF_ROWS   = 64;
    localparam int DEF_COLS   = 64;
    localparam int DEF_NUM_CH = 10;
    localparam int DEF_W      = 32;
    localparam int DEF_A      = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/weight_fetch_seq_raster_addr_cnt.sv
// Row-major raster counter over a ROWS x COLS tile, with column-end and tile-end flags.
module raster_addr_cnt
    import wfetch_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int A    = DEF_A
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [A-1:0] row,
    output logic [A-1:0] col,
    output logic         row_end,
    output logic         last
);

    localparam logic [A-1:0] ROW_MAX = A'(ROWS - 1);
    localparam logic [A-1:0] COL_MAX = A'(COLS - 1);

    assign row_end = (col == COL_MAX);
    assign last    = row_end && (row == ROW_MAX);

    // Column innermost; the row also wraps after the final word so a full tile never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= {A{1'b0}};
            col <= {A{1'b0}};
        end else if (clr) begin
            row <= {A{1'b0}};
            col <= {A{1'b0}};
        end else if (en) begin
            if (row_end) begin
                col <= {A{1'b0}};
                row <= last ? {A{1'b0}} : row + A'(1);
            end else begin
                col <= col + A'(1);
            end
        end else begin
            row <= row;
            col <= col;
        end
    end

endmodule

// File: rtl/weight_fetch_seq.sv
// Walks one weight-buffer channel in raster order and streams each word over valid/ready.
module weight_fetch_seq
    import wfetch_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int W      = DEF_W,
    parameter int A      = DEF_A
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [A-1:0] ch_sel,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [A-1:0] rom_ch,
    output logic [A-1:0] rom_row,
    output logic [A-1:0] rom_col,
    input  logic [W-1:0] rom_data,
    output logic [W-1:0] w_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic         w_row_end,
    output logic         w_last
);

    // One extra bit so NUM_CH == 2**A still compares correctly.
    localparam logic [A:0] NUM_CH_W = (A+1)'(NUM_CH);

    state_t state_r;
    logic   ch_ok_s;
    logic   accept_s;
    logic   cap_s;
    logic   hs_s;
    logic   cnt_row_end_s;
    logic   cnt_last_s;

    // Decode of start acceptance, output-register capture and handshake.
    always_comb begin
        ch_ok_s  = ({1'b0, ch_sel} < NUM_CH_W);
        hs_s     = w_valid && w_ready;
        accept_s = 1'b0;
        cap_s    = 1'b0;
        if (state_r == IDLE) begin
            accept_s = start && ch_ok_s;
        end else if (state_r == RUN) begin
            cap_s = !w_valid || w_ready;
        end else begin
            accept_s = 1'b0;
            cap_s    = 1'b0;
        end
    end

    raster_addr_cnt #(
        .ROWS (ROWS),
        .COLS (COLS),
        .A    (A)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept_s),
        .en      (cap_s),
        .row     (rom_row),
        .col     (rom_col),
        .row_end (cnt_row_end_s),
        .last    (cnt_last_s)
    );

    // Control FSM together with the channel latch and the output beat register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rom_ch    <= {A{1'b0}};
            w_data    <= {W{1'b0}};
            w_valid   <= 1'b0;
            w_row_end <= 1'b0;
            w_last    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        rom_ch  <= ch_sel;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else if (start) begin
                        err  <= 1'b1;
                        done <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (cap_s) begin
                        w_data    <= rom_data;
                        w_row_end <= cnt_row_end_s;
                        w_last    <= cnt_last_s;
                        w_valid   <= 1'b1;
                        if (cnt_last_s) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                DRAIN: begin
                    if (hs_s) begin
                        w_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    w_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_seq.sv
// Scoreboard bench for weight_fetch_seq on a 4x4 tile with a ch*100+row*10+col buffer model.
module tb_weight_fetch_seq;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int NUM_CH = 10;
    localparam int W = 32;
    localparam int A = 12;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [A-1:0] ch_sel;
    logic         busy, done, err;
    logic [A-1:0] rom_ch, rom_row, rom_col;
    logic [W-1:0] rom_data;
    logic [W-1:0] w_data;
    logic         w_valid, w_ready, w_row_end, w_last;

    typedef struct packed {
        logic [31:0] data;
        logic        row_end;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    beats = 0;
    int    done_cnt = 0;
    int    busy_cnt = 0;
    bit    bp_mode = 1'b0;

    logic         pv_valid = 1'b0;
    logic         pv_ready = 1'b0;
    logic [W-1:0] pv_data = '0;
    logic [A-1:0] pv_row = '0;
    logic [A-1:0] pv_col = '0;

    weight_fetch_seq #(
        .ROWS(ROWS), .COLS(COLS), .NUM_CH(NUM_CH), .W(W), .A(A)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_sel(ch_sel),
        .busy(busy), .done(done), .err(err),
        .rom_ch(rom_ch), .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .w_row_end(w_row_end), .w_last(w_last)
    );

    assign rom_data = 32'(rom_ch) * 32'd100 + 32'(rom_row) * 32'd10 + 32'(rom_col);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic push_channel(input int ch);
        beat_t b;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                b.data    = 32'(ch * 100 + r * 10 + c);
                b.row_end = (c == COLS - 1);
                b.last    = (r == ROWS - 1) && (c == COLS - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic do_start(input int ch, input bit expect_ok);
        if (expect_ok) push_channel(ch);
        @(posedge clk);
        #1;
        start  = 1'b1;
        ch_sel = A'(ch);
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    // Downstream ready: always high, or the repeating 1,0,0,1 pattern.
    initial begin
        logic [3:0] pat;
        int idx;
        pat = 4'b1001;
        idx = 0;
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            w_ready = bp_mode ? pat[idx % 4] : 1'b1;
            idx++;
        end
    end

    // Scoreboard pop, stall-stability checks and pulse counters.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            pv_valid = 1'b0;
        end else begin
            if (pv_valid && !pv_ready) begin
                chk("hold_valid", 64'(w_valid), 64'd1);
                chk("hold_data", 64'(w_data), 64'(pv_data));
                chk("hold_row", 64'(rom_row), 64'(pv_row));
                chk("hold_col", 64'(rom_col), 64'(pv_col));
            end
            if (w_valid && w_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(w_data), 64'(e.data));
                    chk("beat_row_end", 64'(w_row_end), 64'(e.row_end));
                    chk("beat_last", 64'(w_last), 64'(e.last));
                end
                beats++;
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            pv_valid = w_valid;
            pv_ready = w_ready;
            pv_data  = w_data;
            pv_row   = rom_row;
            pv_col   = rom_col;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [A-1:0] sv_ch, sv_row, sv_col;
        bit reached;
        rst_n  = 1'b0;
        start  = 1'b0;
        ch_sel = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_valid", 64'(w_valid), 64'd0);
        chk("rst_data", 64'(w_data), 64'd0);
        chk("rst_addr", 64'({rom_ch, rom_row, rom_col}), 64'd0);

        // Nominal run on channel 1
        done_cnt = 0;
        busy_cnt = 0;
        beats = 0;
        do_start(1, 1'b1);
        @(negedge clk);
        chk("nom_busy", 64'(busy), 64'd1);
        chk("nom_valid_e", 64'(w_valid), 64'd0);
        chk("nom_rom_ch", 64'(rom_ch), 64'd1);
        chk("nom_first_addr", 64'({rom_row, rom_col}), 64'd0);
        @(negedge clk);
        chk("nom_valid_e1", 64'(w_valid), 64'd1);
        wait_done("nom_done", 40);
        chk("nom_busy_after", 64'(busy), 64'd0);
        chk("nom_busy_cycles", 64'(busy_cnt), 64'd17);
        chk("nom_beats", 64'(beats), 64'(ROWS * COLS));
        repeat (3) @(negedge clk);
        chk("nom_done_cnt", 64'(done_cnt), 64'd1);
        chk("nom_q_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure with ready pattern 1,0,0,1
        bp_mode = 1'b1;
        beats = 0;
        do_start(1, 1'b1);
        wait_done("bp_done", 200);
        chk("bp_beats", 64'(beats), 64'(ROWS * COLS));
        chk("bp_q_empty", 64'(exp_q.size()), 64'd0);
        bp_mode = 1'b0;
        repeat (2) @(negedge clk);

        // Invalid channel
        sv_ch = rom_ch;
        sv_row = rom_row;
        sv_col = rom_col;
        done_cnt = 0;
        busy_cnt = 0;
        do_start(NUM_CH, 1'b0);
        @(negedge clk);
        chk("inv_err", 64'(err), 64'd1);
        chk("inv_done", 64'(done), 64'd1);
        chk("inv_busy", 64'(busy), 64'd0);
        chk("inv_valid", 64'(w_valid), 64'd0);
        chk("inv_rom", 64'({rom_ch, rom_row, rom_col}), 64'({sv_ch, sv_row, sv_col}));
        @(negedge clk);
        chk("inv_err_sticky", 64'(err), 64'd1);
        chk("inv_done_pulse", 64'(done), 64'd0);
        chk("inv_busy_never", 64'(busy_cnt), 64'd0);
        do_start(3, 1'b1);
        @(negedge clk);
        chk("inv_err_cleared", 64'(err), 64'd0);
        wait_done("inv_next_done", 40);
        repeat (2) @(negedge clk);

        // Start while busy is ignored
        done_cnt = 0;
        do_start(1, 1'b1);
        repeat (5) @(negedge clk);
        do_start(2, 1'b0);
        chk("sb_err", 64'(err), 64'd0);
        wait_done("sb_done", 40);
        repeat (5) @(negedge clk);
        chk("sb_done_cnt", 64'(done_cnt), 64'd1);
        chk("sb_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-stream after beat 5
        beats = 0;
        do_start(1, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (beats >= 5) begin
                reached = 1'b1;
                break;
            end
        end
        chk("mr_reached", 64'(reached), 64'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_done", 64'(done), 64'd0);
        chk("mr_valid", 64'(w_valid), 64'd0);
        chk("mr_data", 64'(w_data), 64'd0);
        chk("mr_flags", 64'({w_row_end, w_last, err}), 64'd0);
        chk("mr_addr", 64'({rom_ch, rom_row, rom_col}), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        do_start(0, 1'b1);
        wait_done("mr_done_after", 40);
        chk("mr_q_empty", 64'(exp_q.size()), 64'd0);

        // Back-to-back: next start issued in the done cycle
        do_start(4, 1'b1);
        wait_done("b2b_first_done", 40);
        push_channel(5);
        start  = 1'b1;
        ch_sel = A'(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_valid", 64'(w_valid), 64'd1);
        chk("b2b_first_word", 64'(w_data), 64'd500);
        wait_done("b2b_second_done", 40);
        chk("b2b_q_empty", 64'(exp_q.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
